// File: rtl/mem_access_unit.sv
// Load/store stage: sub-word steering, memory req/ack handshake with watchdog, core stall.
// Latency: done two cycles after a request with an immediate ack, plus one per wait state; misaligned requests finish in one cycle.
// Backpressure: the core is stalled while an access is in flight; mem_req is held until mem_ack or the watchdog expires.
module mem_access_unit #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              misalign,
    output logic              timeout,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [CNT_W-1:0] waitCnt;
    logic        regWe;
    logic [1:0]  regSize;
    logic        regSign;
    logic [1:0]  regLane;

    logic        reqMisaligned;
    logic [3:0]  beNext;
    logic [31:0] wdataNext;
    logic [31:0] laneData;
    logic [31:0] loadData;
    logic        unusedAddrBits;

    assign unusedAddrBits = ^req_addr[31:ADDR_W+2];

    assign stall = req_valid & ~done;

    // Alignment check and lane steering on the raw request, captured when leaving IDLE.
    always_comb begin
        reqMisaligned = 1'b0;
        beNext        = 4'b1111;
        wdataNext     = req_wdata;
        case (req_size)
            2'b00: begin
                beNext    = 4'b0001 << req_addr[1:0];
                wdataNext = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                reqMisaligned = req_addr[0];
                beNext        = 4'b0011 << req_addr[1:0];
                wdataNext     = {2{req_wdata[15:0]}};
            end
            2'b10:   reqMisaligned = |req_addr[1:0];
            default: reqMisaligned = 1'b1;
        endcase
        if (!req_we) begin
            beNext = 4'b1111;
        end
    end

    always_comb begin
        laneData = mem_rdata >> {regLane, 3'b000};
        loadData = mem_rdata;
        case (regSize)
            2'b00:   loadData = {{24{regSign & laneData[7]}}, laneData[7:0]};
            2'b01:   loadData = {{16{regSign & laneData[15]}}, laneData[15:0]};
            default: loadData = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            waitCnt   <= '0;
            rdata     <= '0;
            done      <= 1'b0;
            misalign  <= 1'b0;
            timeout   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            regWe     <= 1'b0;
            regSize   <= '0;
            regSign   <= 1'b0;
            regLane   <= '0;
        end else begin
            done     <= 1'b0;
            misalign <= 1'b0;
            timeout  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        regWe   <= req_we;
                        regSize <= req_size;
                        regSign <= req_sign;
                        regLane <= req_addr[1:0];
                        if (reqMisaligned) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            misalign <= 1'b1;
                        end else begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= req_addr[ADDR_W+1:2];
                            mem_be    <= beNext;
                            mem_wdata <= wdataNext;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        if (!regWe) begin
                            rdata <= loadData;
                        end
                        state   <= DONE;
                        done    <= 1'b1;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        waitCnt <= '0;
                    end else if (waitCnt == CNT_W'(TIMEOUT - 1)) begin
                        // Watchdog expired: abandon the access and return zero data.
                        rdata   <= '0;
                        state   <= DONE;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        waitCnt <= '0;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    waitCnt <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: driver issues accesses and plays the memory,
// a monitor pops expected responses from a scoreboard queue on every done pulse.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sign;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        misalign;
    logic        timeout;
    logic        mem_req;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    mem_access_unit #(.ADDR_W(10), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size), .req_sign(req_sign),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .done(done), .rdata(rdata), .misalign(misalign), .timeout(timeout),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        to;
        int          start;
        int          lat;
    } exp_t;

    exp_t sbq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sbq.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("rdata", rdata, e.rdata);
                    check("misalign", 32'(misalign), 32'(e.mis));
                    check("timeout", 32'(timeout), 32'(e.to));
                    check("latency", 32'(cyc - e.start), 32'(e.lat));
                end
            end
        end
    end

    task automatic doAccess(
        input logic        we,
        input logic [1:0]  size,
        input logic        sign,
        input logic [31:0] addr,
        input logic [31:0] wdata,
        input logic [31:0] memData,
        input int          ackDelay,
        input logic [31:0] expRdata,
        input logic        expMis,
        input logic        expTo,
        input int          expLat,
        input logic [31:0] expMemAddr,
        input logic [3:0]  expBe,
        input logic [31:0] expWdata
    );
        exp_t        e;
        int          n;
        bit          sawReq, stallOk, stable, finished;
        logic [31:0] fa, fw;
        logic [3:0]  fb;
        logic        fwe;
        fa = '0; fw = '0; fb = '0; fwe = 1'b0;
        @(negedge clk);
        req_we    = we;
        req_size  = size;
        req_sign  = sign;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        mem_ack   = 1'b0;
        e.rdata = expRdata; e.mis = expMis; e.to = expTo; e.start = cyc; e.lat = expLat;
        sbq.push_back(e);
        #1;
        stallOk  = (stall === 1'b1);
        n        = 0;
        sawReq   = 1'b0;
        stable   = 1'b1;
        finished = 1'b0;
        for (int c = 0; c < 40 && !finished; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                finished = 1'b1;
                check("stall_at_done", 32'(stall), 32'd0);
                req_valid = 1'b0;
                mem_ack   = 1'b0;
            end else begin
                if (stall !== 1'b1) stallOk = 1'b0;
                if (mem_req === 1'b1) begin
                    if (!sawReq) begin
                        sawReq = 1'b1;
                        fa = 32'(mem_addr); fb = mem_be; fw = mem_wdata; fwe = mem_we;
                    end else if (32'(mem_addr) !== fa || mem_be !== fb || mem_wdata !== fw || mem_we !== fwe) begin
                        stable = 1'b0;
                    end
                    mem_ack   = (ackDelay >= 0 && n == ackDelay);
                    mem_rdata = memData;
                    n++;
                end else begin
                    mem_ack = 1'b0;
                end
            end
        end
        if (!finished) begin
            check("done_seen", 32'd0, 32'd1);
            req_valid = 1'b0;
            mem_ack   = 1'b0;
        end
        check("stall_busy", 32'(stallOk), 32'd1);
        if (expMis) begin
            check("no_mem_req", 32'(sawReq), 32'd0);
        end else begin
            check("mem_addr", fa, expMemAddr);
            check("mem_be", 32'(fb), 32'(expBe));
            check("mem_wdata", fw, expWdata);
            check("mem_we", 32'(fwe), 32'(we));
            check("req_stable", 32'(stable), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_sign = 1'b0;
        req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_done", 32'(done), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_flags", 32'({misalign, timeout, mem_we}), 32'd0);
        rst = 1'b0;

        //        we    size   sg    addr          wdata         memData       dly rdata         mis   to   lat addr  be       wdata
        doAccess(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 2, 32'd4, 4'b1111, 32'h0);
        doAccess(1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0,        32'h8000_0000, 0, 32'hFFFF_FF80, 1'b0, 1'b0, 2, 32'd4, 4'b1111, 32'h0);
        doAccess(1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0,        32'h8000_0000, 0, 32'h0000_0080, 1'b0, 1'b0, 2, 32'd4, 4'b1111, 32'h0);
        doAccess(1'b1, 2'b01, 1'b0, 32'h0000_0006, 32'h1234_ABCD, 32'hFFFF_FFFF, 0, 32'h0000_0080, 1'b0, 1'b0, 2, 32'd1, 4'b1100, 32'hABCD_ABCD);
        doAccess(1'b0, 2'b10, 1'b0, 32'h0000_0002, 32'h0,        32'h0,         0, 32'h0000_0080, 1'b1, 1'b0, 1, 32'd0, 4'b0000, 32'h0);
        doAccess(1'b0, 2'b01, 1'b0, 32'h0000_0005, 32'h0,        32'h0,         0, 32'h0000_0080, 1'b1, 1'b0, 1, 32'd0, 4'b0000, 32'h0);
        doAccess(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,        32'h0BAD_F00D, 5, 32'h0BAD_F00D, 1'b0, 1'b0, 7, 32'd8, 4'b1111, 32'h0);
        doAccess(1'b0, 2'b01, 1'b1, 32'h0000_0022, 32'h0,        32'h8001_7FFF, 0, 32'hFFFF_8001, 1'b0, 1'b0, 2, 32'd8, 4'b1111, 32'h0);
        doAccess(1'b0, 2'b01, 1'b0, 32'h0000_0020, 32'h0,        32'h8001_7FFF, 0, 32'h0000_7FFF, 1'b0, 1'b0, 2, 32'd8, 4'b1111, 32'h0);
        doAccess(1'b1, 2'b00, 1'b0, 32'h0000_0001, 32'h0000_00A5, 32'h0,        1, 32'h0000_7FFF, 1'b0, 1'b0, 3, 32'd0, 4'b0010, 32'hA5A5_A5A5);
        doAccess(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0,        32'h1111_1111, -1, 32'h0,        1'b0, 1'b1, 17, 32'd16, 4'b1111, 32'h0);
        doAccess(1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0,        32'h0,         0, 32'h0,         1'b1, 1'b0, 1, 32'd0, 4'b0000, 32'h0);
        doAccess(1'b0, 2'b10, 1'b0, 32'h0000_0FFC, 32'h0,        32'h1234_5678, 0, 32'h1234_5678, 1'b0, 1'b0, 2, 32'h3FF, 4'b1111, 32'h0);

        // Reset during the third REQ cycle, then a stray ack.
        @(negedge clk);
        req_we = 1'b0; req_size = 2'b10; req_sign = 1'b0; req_addr = 32'h30; req_valid = 1'b1;
        mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_req_active", 32'(mem_req), 32'd1);
        rst = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_mem_req", 32'(mem_req), 32'd0);
        check("rst_mid_stall", 32'(stall), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        rst = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stray_ack_rdata", rdata, 32'd0);
            check("stray_ack_done", 32'(done), 32'd0);
            check("stray_ack_mem_req", 32'(mem_req), 32'd0);
        end
        mem_ack = 1'b0;

        doAccess(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 1'b0, 1'b0, 2, 32'd4, 4'b1111, 32'h0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store stage directly downstream of the core's ALU: consumes the ALU byte address and the rt store data, and drives the data memory.
- Adds sub-word access (lb/lbu/lh/lhu/sb/sh) through byte enables, lane steering and load extension.
- Adds a request/ack memory handshake with wait states, plus a watchdog.
- Holds the core through the stall output while an access is in flight.

Parameters:
- ADDR_W, 10, width of the word address sent to memory; byte address bits [ADDR_W+1:2].
- TIMEOUT, 16, maximum cycles spent in REQ without mem_ack before the access is aborted (minimum 2).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  core requests an access; held stable until done
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_sign  in  1  1 = sign-extend a sub-word load, 0 = zero-extend
- req_addr  in  32  byte address (ALU result)
- req_wdata  in  32  store data (rt)
- stall  out  1  freeze the core's PC/RF write this cycle
- done  out  1  one-cycle pulse: access complete
- rdata  out  32  aligned, extended load data; valid with done, held until the next done
- misalign  out  1  pulse with done: access rejected for alignment
- timeout  out  1  pulse with done: memory never acked
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  write strobe, qualified by mem_req
- mem_addr  out  ADDR_W  word address
- mem_be  out  4  byte enables, bit i = bits [8i+7:8i]
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory completes the current request this cycle
- mem_rdata  in  32  read word, valid when mem_ack=1

Behaviour:
- Reset: state IDLE, watchdog counter 0, rdata 0.
  - All outputs 0 after reset, including stall (stall also requires req_valid).
- Reset applied mid-access drops mem_req at that same edge. Any later mem_ack is ignored.
- Combinational stall = req_valid & ~done.
- States and transitions:
  - IDLE: if req_valid, register we/size/sign/addr/wdata and check alignment.
    - Aligned access goes to REQ.
    - Misaligned access goes to DONE with the misalign flag set. Misaligned means: half with addr[0]=1; word with addr[1:0]≠0; size 11 with any address.
    - Otherwise stay in IDLE.
  - REQ: mem_req=1; mem_addr/mem_be/mem_wdata/mem_we come from the registered fields and are stable for the whole state.
    - On mem_ack=1: capture the extended read data into rdata (loads only; stores leave rdata unchanged), then go to DONE.
    - The counter increments each REQ cycle without ack. When it reaches TIMEOUT-1 without ack, abort to DONE with the timeout flag set and rdata=0.
  - DONE: done=1, stall=0, the error flag pulses, counter clears; always go to IDLE.
- Latency: a request seen in IDLE at cycle 0 with ack in its first REQ cycle pulses done in cycle 2. Every wait state adds one cycle.
- The core advances on the edge that ends DONE. It must then present the next request or drop req_valid.
- mem_ack outside REQ is ignored. mem_req is never asserted for misaligned accesses.
- Lane rules (little-endian, lane = addr[1:0]):
  - Byte: mem_be = 0001 << lane; mem_wdata = {4{wdata[7:0]}}.
  - Half: mem_be = 0011 << lane (lane 0 or 2); mem_wdata = {2{wdata[15:0]}}.
  - Word: mem_be = 1111.
  - Loads drive mem_be = 1111 and mem_we = 0.
  - Load extension: the selected byte/half is sign- or zero-extended to 32 bits per req_sign; word loads are passed through unchanged.

Test Plan:
- Word load, addr 0x0000_0010, mem_ack in first REQ cycle, mem_rdata 0xDEAD_BEEF -> mem_addr=4, done in cycle 2, rdata=0xDEAD_BEEF, stall high in cycles 0–1.
- lb addr 0x13, sign=1, mem_rdata 0x80_00_00_00 -> rdata=0xFFFF_FF80. Same access with lbu (sign=0) -> rdata=0x0000_0080.
- sh addr 0x06, wdata 0x1234_ABCD -> mem_be=1100, mem_wdata=0xABCD_ABCD, mem_we=1, mem_addr=1.
- Misaligned: lw addr 0x02, and separately lh addr 0x05 -> mem_req never asserted, done and misalign pulse in cycle 1.
- Wait states: mem_ack raised after 5 REQ cycles -> done in cycle 7, with mem_addr/mem_be stable throughout. No ack for 16 cycles -> timeout pulse with done, rdata=0.
- rst asserted in the 3rd REQ cycle -> next cycle mem_req=0, stall=0, state IDLE. A stray mem_ack afterwards has no effect on rdata or done.
